// File: rtl/multicycle_sequencer.sv
// Five-phase instruction sequencer and PC owner for the multi-cycle core.
// Skips MEM for non-memory instructions, stalls on mem_ready with a timeout, supports halt/idle.
module multicycle_sequencer #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    PC_STEP      = 4,
    parameter int                    CNT_WIDTH    = 32,
    parameter int                    MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  halt,
    input  logic                  is_mem,
    input  logic                  mem_ready,
    input  logic                  pc_src,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  fetch_en,
    output logic                  decode_en,
    output logic                  exec_en,
    output logic                  mem_en,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [CNT_WIDTH-1:0]  retired,
    output logic                  halted,
    output logic                  mem_timeout
);

    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_WIDTH-1:0]  retired_q, retired_d;
    logic                  timeout_q, timeout_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;
        case (state_q)
            S_IDLE:   if (!halt) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                wait_d  = '0;
                state_d = is_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    // Abandon the access; pc is left alone so the instruction is retried.
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                pc_d      = pc_src ? branch_target : pc_q + ADDR_WIDTH'(PC_STEP);
                retired_d = retired_q + CNT_WIDTH'(1);
                state_d   = halt ? S_IDLE : S_FETCH;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    assign fetch_en    = (state_q == S_FETCH);
    assign decode_en   = (state_q == S_DECODE);
    assign exec_en     = (state_q == S_EXEC);
    assign mem_en      = (state_q == S_MEM);
    assign wb_en       = (state_q == S_WB);
    assign halted      = (state_q == S_IDLE);
    assign pc          = pc_q;
    assign retired     = retired_q;
    assign mem_timeout = timeout_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised phase sequencer and PC controller for the multi-cycle CPU core.
- Replaces the fixed modulo-4 phase counter with an explicit five-state machine: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Adds skipping of MEM for non-memory instructions, a memory-ready stall handshake with timeout, halt/idle control, and a retired-instruction counter.
- Drives the phase enables of the fetch, register-file, data-memory and writeback paths, and owns the architectural PC.

Parameters:
- ADDR_WIDTH, 32, width of pc and branch_target.
- RESET_PC, 0, value loaded into pc on reset.
- PC_STEP, 4, sequential PC increment.
- CNT_WIDTH, 32, width of retired counter.
- MEM_WAIT_MAX, 15, maximum MEM cycles with mem_ready low before timeout (must be ≥1).

Ports:
- clk  in  1  rising-edge clock.
- nreset  in  1  synchronous, active-high reset (1 = reset, despite the name).
- halt  in  1  stop request; honoured only in WRITEBACK and IDLE.
- is_mem  in  1  current instruction accesses data memory (MemRead|MemWrite); sampled in EXECUTE.
- mem_ready  in  1  data memory completed access; sampled in MEM.
- pc_src  in  1  take branch (Branch & Zero); sampled in WRITEBACK.
- branch_target  in  ADDR_WIDTH  branch destination; sampled in WRITEBACK.
- fetch_en  out  1  high in FETCH.
- decode_en  out  1  high in DECODE (register read enable).
- exec_en  out  1  high in EXECUTE.
- mem_en  out  1  high in MEM.
- wb_en  out  1  high in WRITEBACK (register/memory write enable).
- pc  out  ADDR_WIDTH  current instruction address.
- retired  out  CNT_WIDTH  instructions completed since reset.
- halted  out  1  high in IDLE.
- mem_timeout  out  1  sticky error flag.

Behaviour:
- Moore machine: all enables and halted decode from the state register only. At most one of fetch_en, decode_en, exec_en, mem_en, wb_en is high in any cycle.
- Reset: in any cycle with nreset=1, on the edge:
  - state<=IDLE, pc<=RESET_PC, retired<=0, mem_timeout<=0, wait counter<=0.
  - Outputs after reset: all enables 0, halted=1.
  - Reset overrides every other input, including in WRITEBACK; no pc or retired update occurs on a reset edge.
- State transitions:
  - IDLE: halt=0 → FETCH; else stay.
  - FETCH → DECODE → EXECUTE, one cycle each, unconditional.
  - EXECUTE: is_mem=1 → MEM (wait counter cleared); else → WRITEBACK.
  - MEM, mem_ready=1 → WRITEBACK.
  - MEM, mem_ready=0 and wait counter = MEM_WAIT_MAX-1 → IDLE, mem_timeout<=1, pc and retired unchanged.
  - MEM, otherwise: stay, wait counter +1.
  - WRITEBACK: pc<=pc_src ? branch_target : pc+PC_STEP; retired<=retired+1; then halt=1 → IDLE, else → FETCH.
- Latency: non-memory instruction 4 cycles; memory instruction 5+k cycles, where k = MEM cycles with mem_ready low (k < MEM_WAIT_MAX).
- Arithmetic:
  - pc+PC_STEP wraps modulo 2^ADDR_WIDTH.
  - retired wraps modulo 2^CNT_WIDTH.
  - branch_target is used as-is; no alignment check.
- halt asserted in FETCH through MEM has no effect until WRITEBACK; the instruction in flight always completes.
- mem_timeout clears only on reset. Leaving IDLE after a timeout restarts at the unchanged pc, so the instruction is retried.
- mem_ready and is_mem are ignored outside MEM and EXECUTE respectively. pc_src and branch_target are ignored outside WRITEBACK.

Test Plan:
- Reset then halt=0, is_mem=0, pc_src=0 for 12 cycles → enables cycle IDLE,F,D,E,WB,F,D,E,WB,F,...; pc 0→4→8; retired 0→1→2; mem_en never high.
- is_mem=1, mem_ready low 3 MEM cycles then high → mem_en high 4 cycles, wb_en 1 cycle later; instruction latency 8 cycles; pc=4, retired=1.
- pc_src=1, branch_target=0x40 at WRITEBACK → next fetch_en cycle shows pc=0x40. ADDR_WIDTH=8, pc=0xFC, no branch → pc=0x00.
- halt raised during DECODE → instruction completes, retired+1, state IDLE, halted=1; halt dropped → FETCH next cycle.
- is_mem=1, mem_ready held 0 (MEM_WAIT_MAX=15) → 15 MEM cycles, then IDLE, mem_timeout=1, pc and retired unchanged; flag persists until reset.
- nreset=1 asserted during WRITEBACK with pc=8 → next cycle pc=0, retired=0, state IDLE, all enables 0.
